timer: RTL and testbench
========================

TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter: PRESCBITS, 16, width of prescaler reload and prescaler counter.
REQ-002 SHALL have port: clk_i  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: adr_i  input  2  word address (bus adr[3:2]) selecting register.
REQ-005 SHALL have port: sel_i  input  4  byte enables; sel_i[n] covers dat_i[8n+7:8n].
REQ-006 SHALL have port: stb_i  input  1  Wishbone strobe, pre-qualified by address decode and cyc.
REQ-007 SHALL have port: we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: dat_i  input  32  write data.
REQ-009 SHALL have port: dat_o  output  32  read data, valid while ack_o high.
REQ-010 SHALL have port: ack_o  output  1  Wishbone acknowledge.
REQ-011 SHALL have port: irq_o  output  1  level interrupt request.

Function
REQ-012 SHALL map registers: 0=CTRL, 1=PRESC, 2=COUNT, 3=COMPARE.
REQ-013 SHALL define CTRL bits: [0] EN, [1] PERIODIC, [2] IRQEN, [8] MATCH (read; write-1-to-clear); other bits read 0, writes ignored.
REQ-014 SHALL hold PRESC[PRESCBITS-1:0]; upper bits read 0.
REQ-015 SHALL assert ack_o exactly one cycle after a cycle in which stb_i=1 and ack_o=0, for one cycle only; stb_i held high gives ack every second cycle.
REQ-016 SHALL perform register writes on the clock edge that raises ack_o, honouring sel_i per byte.
REQ-017 SHALL drive dat_o from a register captured on the same edge that raises ack_o; dat_o = 0 when ack_o = 0.
REQ-018 SHALL, while EN=1, increment the prescaler counter each cycle; when it equals PRESC it returns to 0 and produces a one-cycle tick (PRESC=0 gives tick every cycle).
REQ-019 SHALL hold the prescaler counter at 0 while EN=0.
REQ-020 SHALL on tick with COUNT != COMPARE increment COUNT modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
REQ-021 SHALL on tick with COUNT == COMPARE set MATCH; if PERIODIC=1 load COUNT=0, else hold COUNT and clear EN (one-shot).
REQ-022 SHALL give a bus write to COUNT priority over a simultaneous tick update.
REQ-023 SHALL give MATCH set priority over a simultaneous write-1-to-clear.
REQ-024 SHALL give hardware EN clear (one-shot) priority over a simultaneous bus write setting EN.
REQ-025 SHALL drive irq_o = MATCH & IRQEN, from registered state only (no combinational path from bus inputs).
REQ-026 SHALL return on read of CTRL the MATCH value before any same-access clear.

Reset
REQ-027 SHALL on rst_i=1 immediately clear CTRL, PRESC, COUNT, prescaler counter, ack_o, dat_o; set COMPARE=0xFFFFFFFF; irq_o=0.
REQ-028 SHALL abort an in-flight access on reset; no write is performed and no ack follows.

Verification
REQ-029 SHALL cover: read each register after reset -> CTRL=0, PRESC=0, COUNT=0, COMPARE=0xFFFFFFFF, ack one cycle after stb.
REQ-030 SHALL cover: PRESC=3, COMPARE=5, CTRL=0x7 -> MATCH and irq_o rise 24 cycles after EN, COUNT returns 0, repeats every 24 cycles.
REQ-031 SHALL cover: CTRL=0x5 (one-shot), COMPARE=2, PRESC=0 -> MATCH set, EN reads 0, COUNT holds 2; write CTRL=0x100 -> irq_o falls next cycle.
REQ-032 SHALL cover: COUNT=0xFFFFFFFE, COMPARE=0x10, PRESC=0, EN -> COUNT reads 0xFFFFFFFF then 0x0, MATCH stays 0.
REQ-033 SHALL cover: byte write sel_i=4'b0010 dat_i=0xAABBCCDD to COMPARE -> COMPARE=0xFFFFCCFF; simultaneous tick and COUNT write -> written value wins.
REQ-034 SHALL cover: rst_i pulsed mid-count and during stb -> outputs 0 without waiting for clock, no ack, registers at reset values.

Source files
------------

// File: rtl/timer.sv
// Wishbone-attached 32-bit timer: prescaler, up-counter with compare,
// sticky match flag and a level interrupt.
module timer #(
  parameter int PRESCBITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_PRESC   = 2'd1;
  localparam logic [1:0] A_COUNT   = 2'd2;
  localparam logic [1:0] A_COMPARE = 2'd3;

  logic                 en, periodic, irqen, match;
  logic [PRESCBITS-1:0] presc, pcnt;
  logic [31:0]          count, compare;

  logic        access, wr;
  logic        wr_ctrl, wr_presc, wr_count, wr_compare;
  logic        tick, hit;
  logic [31:0] rdata, presc_ext, presc_new;

  // Byte-lane merge of write data into an existing 32-bit value.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // A new access starts when strobe is seen and no ack is pending; the
  // ack cycle itself never starts another, giving ack every second cycle.
  assign access     = stb_i & ~ack_o;
  assign wr         = access & we_i;
  assign wr_ctrl    = wr & (adr_i == A_CTRL);
  assign wr_presc   = wr & (adr_i == A_PRESC);
  assign wr_count   = wr & (adr_i == A_COUNT);
  assign wr_compare = wr & (adr_i == A_COMPARE);

  assign tick = en & (pcnt == presc);
  assign hit  = tick & (count == compare);

  assign presc_ext = 32'(presc);
  assign presc_new = merge(presc_ext, dat_i, sel_i);

  // Read mux; MATCH is the pre-clear value because it is sampled before the edge.
  always_comb begin
    rdata = 32'h0;
    case (adr_i)
      A_CTRL:    rdata = {23'h0, match, 5'h0, irqen, periodic, en};
      A_PRESC:   rdata = presc_ext;
      A_COUNT:   rdata = count;
      A_COMPARE: rdata = compare;
      default:   rdata = 32'h0;
    endcase
  end

  // Bus handshake: ack and read data registered on the access edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= 32'h0;
    end else begin
      ack_o <= access;
      dat_o <= access ? rdata : 32'h0;
    end
  end

  // EN: a one-shot match clears it even if the bus is setting it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   en <= 1'b0;
    else if (hit && !periodic)   en <= 1'b0;
    else if (wr_ctrl && sel_i[0]) en <= dat_i[0];
  end

  // PERIODIC and IRQEN are plain control bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      periodic <= 1'b0;
      irqen    <= 1'b0;
    end else if (wr_ctrl && sel_i[0]) begin
      periodic <= dat_i[1];
      irqen    <= dat_i[2];
    end
  end

  // MATCH: set on compare hit, write-1-to-clear; set wins over clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              match <= 1'b0;
    else if (hit)                           match <= 1'b1;
    else if (wr_ctrl && sel_i[1] && dat_i[8]) match <= 1'b0;
  end

  // Prescaler reload register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         presc <= '0;
    else if (wr_presc) presc <= presc_new[PRESCBITS-1:0];
  end

  // Prescaler counter: runs only while enabled, wraps to 0 on tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     pcnt <= '0;
    else if (!en)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  // Main counter: bus write beats the tick update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 count <= 32'h0;
    else if (wr_count)         count <= merge(count, dat_i, sel_i);
    else if (hit && periodic)  count <= 32'h0;
    else if (tick && !hit)     count <= count + 32'd1;
  end

  // Compare register resets to all-ones so an idle timer never matches early.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           compare <= 32'hFFFF_FFFF;
    else if (wr_compare) compare <= merge(compare, dat_i, sel_i);
  end

  assign irq_o = match & irqen;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: reads push expected data, the ack monitor pops.
module tb_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] dat_o;
  logic        ack_o, irq_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  bit          sb_rd[$];
  logic [31:0] sb_d[$];
  string       sb_tag[$];

  timer #(.PRESCBITS(16)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .sel_i(sel), .stb_i(stb),
    .we_i(we), .dat_i(wdat), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Ack monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ack_o) begin
      if (sb_rd.size() == 0) chk("unexpected_ack", 32'(ack_o), 0);
      else begin
        bit          r;
        logic [31:0] d;
        string       t;
        r = sb_rd.pop_front();
        d = sb_d.pop_front();
        t = sb_tag.pop_front();
        if (r) chk(t, dat_o, d);
      end
    end else if (dat_o !== 32'h0) chk("dat_idle", dat_o, 0);
  end

  task automatic bus(input bit w, input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    sb_rd.push_back(!w); sb_d.push_back(exp); sb_tag.push_back(tag);
    @(posedge clk); #1;
    acc_cyc = cyc;
    stb = 1'b0; we = 1'b0;
    chk({tag, "_ack"}, 32'(ack_o), 1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, a, 4'hF, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, a, 4'hF, 32'h0, exp, tag);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Bounded wait for irq_o high; returns the edge number where it was seen.
  task automatic wait_irq(output int at);
    bit found;
    found = 0;
    at = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk); #1;
      if (irq_o) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) chk("irq_timeout", 0, 1);
  endtask

  initial begin
    int r1, r2, e0;
    // Reset state, before any clock edge.
    #3;
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", 32'(irq_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Register values after reset.
    rd(2'd0, 32'h0, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_presc");
    rd(2'd2, 32'h0, "rst_count");
    rd(2'd3, 32'hFFFF_FFFF, "rst_compare");

    // Strobe held high: acks on alternate cycles.
    @(posedge clk); #1;
    stb = 1'b1; we = 1'b0; adr = 2'd3; sel = 4'hF;
    repeat (2) begin
      sb_rd.push_back(1'b1); sb_d.push_back(32'hFFFF_FFFF); sb_tag.push_back("held_rd");
    end
    @(posedge clk); #1; chk("held_ack0", 32'(ack_o), 1);
    @(posedge clk); #1; chk("held_ack1", 32'(ack_o), 0);
    @(posedge clk); #1; chk("held_ack2", 32'(ack_o), 1);
    stb = 1'b0;

    // PRESC upper bits read back zero.
    wr(2'd1, 32'hABCD_0007);
    rd(2'd1, 32'h0000_0007, "presc_mask");

    // Periodic: match every 24 cycles with PRESC=3, COMPARE=5.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd3, 32'd5);
    wr(2'd0, 32'h7);
    e0 = acc_cyc;
    wait_irq(r1);
    chk("per_first", 32'(r1 - e0), 24);
    rd(2'd2, 32'h0, "per_count0");
    rd(2'd0, 32'h107, "per_ctrl");
    bus(1'b1, 2'd0, 4'h3, 32'h107, 32'h0, "per_clr");
    chk("per_irq_clr", 32'(irq_o), 0);
    wait_irq(r2);
    chk("per_period", 32'(r2 - r1), 24);

    // One-shot: EN clears, COUNT holds, W1C drops irq.
    do_reset();
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h5);
    repeat (6) @(posedge clk);
    #1;
    chk("os_irq", 32'(irq_o), 1);
    rd(2'd0, 32'h104, "os_ctrl");
    rd(2'd2, 32'd2, "os_count");
    wr(2'd0, 32'h100);
    chk("os_irq_fall", 32'(irq_o), 0);
    rd(2'd0, 32'h0, "os_ctrl_clr");

    // Wrap: 0xFFFFFFFE -> 0xFFFFFFFF -> 0, no match.
    do_reset();
    wr(2'd2, 32'hFFFF_FFFE);
    wr(2'd3, 32'h10);
    wr(2'd0, 32'h1);
    rd(2'd2, 32'hFFFF_FFFF, "wrap_ff");
    do_reset();
    wr(2'd2, 32'hFFFF_FFFE);
    wr(2'd3, 32'h10);
    wr(2'd0, 32'h1);
    @(posedge clk); #1;
    rd(2'd2, 32'h0, "wrap_0");
    rd(2'd0, 32'h1, "wrap_nomatch");

    // Byte write to COMPARE, then COUNT write racing a tick.
    do_reset();
    bus(1'b1, 2'd3, 4'b0010, 32'hAABB_CCDD, 32'h0, "bytewr");
    rd(2'd3, 32'hFFFF_CCFF, "byte_compare");
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h1234);
    rd(2'd2, 32'h1235, "cnt_wr_wins");

    // Reset mid-count with an ack in flight.
    do_reset();
    wr(2'd3, 32'd3);
    wr(2'd0, 32'h7);
    wait_irq(r1);
    @(posedge clk); #1;
    stb = 1'b1; we = 1'b0; adr = 2'd0; sel = 4'hF;
    @(posedge clk); #1;
    chk("abort_ack_pre", 32'(ack_o), 1);
    rst = 1'b1;
    #1;
    chk("abort_ack", 32'(ack_o), 0);
    chk("abort_dat", dat_o, 0);
    chk("abort_irq", 32'(irq_o), 0);
    stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    // Reset during a pending write strobe.
    stb = 1'b1; we = 1'b1; adr = 2'd2; wdat = 32'h55;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_noack", 32'(ack_o), 0);
    stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    rd(2'd2, 32'h0, "abort_count");
    rd(2'd0, 32'h0, "abort_ctrl");
    rd(2'd1, 32'h0, "abort_presc");
    rd(2'd3, 32'hFFFF_FFFF, "abort_compare");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_rd.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
